// File: rtl/llc_mem_serdes_pkg.sv
// llc_mem_serdes_pkg: shared constants and types for the LLC memory serdes bridge
package llc_mem_serdes_pkg;
  localparam int WORD_BITS      = 64;
  localparam int WORDS_PER_LINE = 4;
  localparam int LINE_ADDR_BITS = 26;
  localparam int BEAT_BITS      = $clog2(WORDS_PER_LINE);
  localparam int BYTE_BITS      = $clog2(WORD_BITS / 8);
  localparam int OFFSET_BITS    = BEAT_BITS + BYTE_BITS;
  localparam int ADDR_BITS      = LINE_ADDR_BITS + OFFSET_BITS;
  localparam int LINE_BITS      = WORD_BITS * WORDS_PER_LINE;
  typedef logic [2:0]                hsize_t;
  typedef logic [1:0]                hprot_t;
  typedef logic [LINE_ADDR_BITS-1:0] line_addr_t;
  typedef logic [LINE_BITS-1:0]      line_t;
  typedef logic [WORD_BITS-1:0]      word_t;
  typedef logic [BEAT_BITS-1:0]      beat_t;
  typedef enum logic [2:0] {IDLE, WR_BEAT, RD_REQ, RD_DATA, RSP} llc_mem_serdes_state_t;
endpackage

// File: rtl/llc_mem_serdes.sv
// llc_mem_serdes: serialises LLC line requests into memory beats and reassembles read lines
module llc_mem_serdes
  import llc_mem_serdes_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      llc_mem_req_valid,
  output logic                      llc_mem_req_ready,
  input  logic                      llc_mem_req_hwrite,
  input  logic [2:0]                llc_mem_req_hsize,
  input  logic [1:0]                llc_mem_req_hprot,
  input  logic [LINE_ADDR_BITS-1:0] llc_mem_req_addr,
  input  logic [LINE_BITS-1:0]      llc_mem_req_line,
  output logic                      llc_mem_rsp_valid,
  input  logic                      llc_mem_rsp_ready,
  output logic [LINE_BITS-1:0]      llc_mem_rsp_line,
  output logic                      mem_req_valid,
  input  logic                      mem_req_ready,
  output logic                      mem_req_write,
  output logic [ADDR_BITS-1:0]      mem_req_addr,
  output logic [2:0]                mem_req_hsize,
  output logic [1:0]                mem_req_hprot,
  output logic [WORD_BITS-1:0]      mem_req_wdata,
  output logic                      mem_req_last,
  input  logic                      mem_rsp_valid,
  output logic                      mem_rsp_ready,
  input  logic [WORD_BITS-1:0]      mem_rsp_rdata
);
  localparam beat_t BEAT_MAX = beat_t'(WORDS_PER_LINE - 1);
  llc_mem_serdes_state_t state, state_n;
  beat_t      beat;
  line_addr_t addr_q;
  hsize_t     hsize_q;
  hprot_t     hprot_q;
  line_t      line_q;
  logic       accept, wr_hs, rq_hs, rd_hs;
  assign accept = state == IDLE && llc_mem_req_valid;
  assign wr_hs  = state == WR_BEAT && mem_req_ready;
  assign rq_hs  = state == RD_REQ && mem_req_ready;
  assign rd_hs  = state == RD_DATA && mem_rsp_valid;
  // state register
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_n;
  // next-state: direction is encoded in the state, so hwrite need not be kept
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = llc_mem_req_valid ? (llc_mem_req_hwrite ? WR_BEAT : RD_REQ) : IDLE;
      WR_BEAT: state_n = (mem_req_ready && beat == BEAT_MAX) ? IDLE : WR_BEAT;
      RD_REQ:  state_n = mem_req_ready ? RD_DATA : RD_REQ;
      RD_DATA: state_n = (mem_rsp_valid && beat == BEAT_MAX) ? RSP : RD_DATA;
      RSP:     state_n = llc_mem_rsp_ready ? IDLE : RSP;
      default: state_n = IDLE;
    endcase
  end
  // request fields, beat counter and the line buffer shared by write data and read assembly
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      beat    <= '0;
      addr_q  <= '0;
      hsize_q <= '0;
      hprot_q <= '0;
      line_q  <= '0;
    end else if (accept) begin
      beat    <= '0;
      addr_q  <= llc_mem_req_addr;
      hsize_q <= llc_mem_req_hsize;
      hprot_q <= llc_mem_req_hprot;
      line_q  <= llc_mem_req_line;
    end else if (wr_hs || rd_hs) begin
      beat <= beat + 1'b1;
      if (rd_hs) line_q[int'(beat)*WORD_BITS +: WORD_BITS] <= mem_rsp_rdata;
    end else if (rq_hs) beat <= '0;
  assign llc_mem_req_ready = state == IDLE;
  assign llc_mem_rsp_valid = state == RSP;
  assign llc_mem_rsp_line  = line_q;
  assign mem_req_valid     = state == WR_BEAT || state == RD_REQ;
  assign mem_req_write     = state == WR_BEAT;
  assign mem_req_addr      = state == WR_BEAT ? {addr_q, beat, {BYTE_BITS{1'b0}}} :
                             state == RD_REQ  ? {addr_q, {OFFSET_BITS{1'b0}}} : '0;
  assign mem_req_hsize     = hsize_q;
  assign mem_req_hprot     = hprot_q;
  assign mem_req_wdata     = state == WR_BEAT ? line_q[int'(beat)*WORD_BITS +: WORD_BITS] : '0;
  assign mem_req_last      = state == WR_BEAT ? beat == BEAT_MAX : state == RD_REQ;
  assign mem_rsp_ready     = state == RD_DATA;
endmodule

// File: doc/llc_mem_serdes.md
# llc_mem_serdes

Word-serialising bridge directly downstream of the LLC's memory request channel and upstream of its memory response channel. It accepts one full-line memory request at a time from the LLC (write-back or line fill) and converts it into word-wide beats on a narrow memory bus. For reads it reassembles the returned data beats into one line and presents it to the LLC as a line-wide memory response. Writes produce no response to the LLC.

## Interface
Parameters:
- WORD_BITS, 64, bits per memory beat (power of 2, ≥ 8)
- WORDS_PER_LINE, 4, beats per line (power of 2, ≥ 2)
- LINE_ADDR_BITS, 26, width of line address
- OFFSET_BITS (derived) = clog2(WORDS_PER_LINE) + clog2(WORD_BITS/8); ADDR_BITS = LINE_ADDR_BITS + OFFSET_BITS

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- llc_mem_req_valid  in  1  LLC request valid
- llc_mem_req_ready  out  1  bridge can accept a request
- llc_mem_req_hwrite  in  1  1 = write line, 0 = read line
- llc_mem_req_hsize  in  3  forwarded on every beat
- llc_mem_req_hprot  in  2  forwarded on every beat
- llc_mem_req_addr  in  LINE_ADDR_BITS  line address
- llc_mem_req_line  in  WORD_BITS*WORDS_PER_LINE  write data
- llc_mem_rsp_valid  out  1  assembled line valid
- llc_mem_rsp_ready  in  1  LLC accepts line
- llc_mem_rsp_line  out  WORD_BITS*WORDS_PER_LINE  assembled read line
- mem_req_valid / mem_req_ready  out / in  1 / 1  beat request handshake
- mem_req_write  out  1  beat is write
- mem_req_addr  out  ADDR_BITS  byte address of beat (reads: line base)
- mem_req_hsize / mem_req_hprot  out  3 / 2  registered copies
- mem_req_wdata  out  WORD_BITS  write beat data
- mem_req_last  out  1  final beat of the transaction
- mem_rsp_valid / mem_rsp_ready  in / out  1 / 1  read data beat handshake
- mem_rsp_rdata  in  WORD_BITS  read beat data

## Operation
- FSM states: IDLE, WR_BEAT, RD_REQ, RD_DATA, RSP.
- IDLE: llc_mem_req_ready = 1. On valid&ready, register hwrite, hsize, hprot, addr, line; clear beat counter; go WR_BEAT if hwrite else RD_REQ.
- WR_BEAT: mem_req_valid = 1, write = 1, addr = {line_addr, beat, OFFSET zeros for byte bits}, wdata = line word[beat] (word 0 = bits WORD_BITS-1:0), last = (beat == WORDS_PER_LINE-1). On handshake: beat++; if last → IDLE.
- RD_REQ: single burst request, write = 0, addr = {line_addr, all-zero offset}, last = 1, wdata = 0. On handshake → RD_DATA, beat cleared.
- RD_DATA: mem_rsp_ready = 1. Each mem_rsp handshake writes rdata into line word[beat], beat++; on beat WORDS_PER_LINE-1 → RSP.
- RSP: llc_mem_rsp_valid = 1, line stable. On llc_mem_rsp_ready → IDLE.
- Beat counter is clog2(WORDS_PER_LINE) bits, wraps naturally to 0 after last beat.
- mem_rsp_valid outside RD_DATA is ignored (ready = 0); no beats are dropped or reordered.

## Timing
- Reset (rst = 0, any state, mid-transaction included): state IDLE, beat 0, all registered fields and line buffer 0; outputs: llc_mem_req_ready 1, llc_mem_rsp_valid 0, llc_mem_rsp_line 0, mem_req_valid 0, mem_req_write 0, mem_req_addr 0, mem_req_hsize 0, mem_req_hprot 0, mem_req_wdata 0, mem_req_last 0, mem_rsp_ready 0. In-flight transaction discarded.
- All outputs are driven from registers/state only; no combinational input→output path except none (ready signals derive from state).
- Acceptance to first mem_req_valid: 1 cycle.
- Write with mem_req_ready held 1: WORDS_PER_LINE cycles of beats, then IDLE; next accept earliest 1 cycle after last beat.
- Read: 1 request cycle (min), then one cycle per data beat, RSP asserted the cycle after last beat; minimum WORDS_PER_LINE+2 cycles accept→rsp_valid.
- mem_req_* and llc_mem_rsp_* held stable while valid and not ready.

## Structure
- Shared package (cache_consts/cache_types): WORD_BITS, WORDS_PER_LINE, LINE_ADDR_BITS, OFFSET_BITS, hsize_t, hprot_t, line_addr_t, line_t, word_t; add a state enum llc_mem_serdes_state_t.
- Single module; no sub-module needed. Line buffer shared between write data and read assembly.

## Test plan
- Write line addr 0x0000123, line words {0x11..,0x22..,0x33..,0x44..}, mem_req_ready=1 → 4 beats at byte addrs 0x2460,0x2468,0x2470,0x2478 (64-bit words), last only on 4th, no llc_mem_rsp_valid.
- Read addr 0x0000040, data beats 0xA,0xB,0xC,0xD → one request addr 0x800 last=1, then llc_mem_rsp_line = {D,C,B,A}, valid held until ready.
- Backpressure: mem_req_ready toggling 0/1 and llc_mem_rsp_ready low 5 cycles → outputs stable while stalled, llc_mem_req_ready stays 0.
- Gaps in mem_rsp_valid (beats every 3rd cycle) plus spurious mem_rsp_valid in IDLE → correct line, spurious beat not captured.
- rst asserted during beat 2 of write → next cycle all outputs at reset values; following read completes correctly.
- Back-to-back write then read with valid held → second request accepted first cycle in IDLE after write's last beat.
